// File: rtl/song_reader_if.sv
// song_reader control, ROM and note-player signals.
// master = MCU/ROM/player side, slave = song_reader.
interface song_reader_if #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic                      play;
  logic                      reset_player;
  logic [SONG_W-1:0]         song;
  logic                      note_done;
  logic [SONG_W+IDX_W-1:0]   rom_addr;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [NOTE_W-1:0]         note;
  logic [DUR_W-1:0]          duration;
  logic                      new_note;
  logic                      song_done;
  logic [IDX_W-1:0]          note_index;

  modport master (
    output play, reset_player, song,
    output note_done, rom_data,
    input  rom_addr, note, duration,
    input  new_note, song_done, note_index
  );

  modport slave (
    input  play, reset_player, song,
    input  note_done, rom_data,
    output rom_addr, note, duration,
    output new_note, song_done, note_index
  );
endinterface

// File: rtl/song_reader.sv
// Walks a song's note list in a sync ROM, one note per note_done.
// Define SONG_END_MARKER_EN to treat duration 0 as end-of-song.
module song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input logic         clk,
  input logic         reset,
  song_reader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ROM_WAIT,
    ISSUE,
    WAIT_NOTE,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = '1;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic              new_note_q;
  logic              song_done_q;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign {rom_note, rom_dur} = bus.rom_data;
  assign idx_d = idx_q + 1'b1;

  assign bus.rom_addr   = {bus.song, idx_q};
  assign bus.note       = note_q;
  assign bus.duration   = dur_q;
  assign bus.new_note   = new_note_q;
  assign bus.song_done  = song_done_q;
  assign bus.note_index = idx_q;

  // ISSUE/DONE only move on once their pulse has been seen with
  // play high; a pause drops the pulse and it is replayed on resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else if (bus.reset_player) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      if (bus.play) begin
        unique case (state_q)
          IDLE:  state_q <= FETCH;
          FETCH: state_q <= ROM_WAIT;
          ROM_WAIT: begin
`ifdef SONG_END_MARKER_EN
            if (rom_dur == '0) begin
              state_q     <= DONE;
              song_done_q <= 1'b1;
            end else begin
              note_q     <= rom_note;
              dur_q      <= rom_dur;
              new_note_q <= 1'b1;
              state_q    <= ISSUE;
            end
`else
            note_q     <= rom_note;
            dur_q      <= rom_dur;
            new_note_q <= 1'b1;
            state_q    <= ISSUE;
`endif
          end
          ISSUE: begin
            if (new_note_q) state_q <= WAIT_NOTE;
            else            new_note_q <= 1'b1;
          end
          WAIT_NOTE: begin
            if (bus.note_done) begin
              if (idx_q == LAST) begin
                state_q     <= DONE;
                song_done_q <= 1'b1;
              end else begin
                idx_q   <= idx_d;
                state_q <= FETCH;
              end
            end
          end
          DONE: begin
            if (song_done_q) begin
              state_q <= IDLE;
              idx_q   <= '0;
            end else begin
              song_done_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a synchronous ROM model.
// Build with +define+SONG_END_MARKER_EN to exercise the marker.
module tb_song_reader;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   nn_cnt = 0;
  int   sd_cnt = 0;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input logic [6:0] a);
    logic [5:0] n;
    logic [5:0] d;
    n = a[5:0] ^ 6'h2A;
    d = (a == 7'h23) ? 6'd0 : {1'b1, a[4:0]};
    return {n, d};
  endfunction

  always_ff @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

  always @(negedge clk) begin
    if (bus.new_note === 1'b1) nn_cnt++;
    if (bus.song_done === 1'b1) sd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(output bit got);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.new_note === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    bus.note_done = 1'b1;
    tick();
    bus.note_done = 1'b0;
  endtask

  task automatic restart(input logic [1:0] s);
    bus.reset_player = 1'b1;
    bus.song = s;
    tick();
    bus.reset_player = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.play = 1'b0;
    bus.reset_player = 1'b0;
    bus.song = 2'd2;
    bus.note_done = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({bus.new_note, bus.song_done} !== 2'b00)
      $display("FAIL reset_pulses got=%b exp=00", {bus.new_note, bus.song_done});
    else n_pass++;
    n_chk++;
    if ({bus.note, bus.duration} !== 12'h000)
      $display("FAIL reset_note got=%h exp=000", {bus.note, bus.duration});
    else n_pass++;
    n_chk++;
    if (bus.note_index !== 5'd0)
      $display("FAIL reset_index got=%0d exp=0", bus.note_index);
    else n_pass++;
    n_chk++;
    if (bus.rom_addr !== 7'h40)
      $display("FAIL reset_addr got=%h exp=40", bus.rom_addr);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_note();
    bus.play = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_chk++;
      if (bus.new_note !== (c == 3))
        $display("FAIL first_latency c=%0d got=%b exp=%b", c, bus.new_note, c == 3);
      else n_pass++;
    end
    n_chk++;
    if ({bus.note, bus.duration} !== rom_word(7'h40))
      $display("FAIL first_data got=%h exp=%h",
               {bus.note, bus.duration}, rom_word(7'h40));
    else n_pass++;
  endtask

  task automatic test_full_song();
    int nn0, sd0;
    bit got;
    logic [6:0] a;
    nn0 = nn_cnt;
    sd0 = sd_cnt;
    for (int i = 0; i < 32; i++) begin
      a = 7'h40 + 7'(i);
      if (i > 0) begin
        wait_issue(got);
        n_chk++;
        if (!got) $display("FAIL song_timeout i=%0d got=0 exp=1", i);
        else n_pass++;
      end
      n_chk++;
      if ({bus.rom_addr, bus.note, bus.duration} !== {a, rom_word(a)})
        $display("FAIL song_note i=%0d got=%h/%h exp=%h/%h", i, bus.rom_addr,
                 {bus.note, bus.duration}, a, rom_word(a));
      else n_pass++;
      tick();
      pulse_done();
    end
    n_chk++;
    if (bus.song_done !== 1'b1)
      $display("FAIL song_done got=%b exp=1", bus.song_done);
    else n_pass++;
    tick();
    bus.play = 1'b0;
    n_chk++;
    if ({bus.song_done, bus.note_index} !== 6'd0)
      $display("FAIL song_end got=%b/%0d exp=0/0", bus.song_done, bus.note_index);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (nn_cnt - nn0 !== 32 || sd_cnt - sd0 !== 1)
      $display("FAIL song_counts got=%0d/%0d exp=32/1", nn_cnt - nn0, sd_cnt - sd0);
    else n_pass++;
  endtask

  task automatic test_pause_rom_wait();
    int nn0;
    restart(2'd1);
    nn0 = nn_cnt;
    bus.play = 1'b1;
    tick();
    tick();
    bus.play = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++;
      if ({bus.new_note, bus.rom_addr} !== {1'b0, 7'h20})
        $display("FAIL pause_hold c=%0d got=%b/%h exp=0/20", c, bus.new_note, bus.rom_addr);
      else n_pass++;
    end
    bus.play = 1'b1;
    tick();
    n_chk++;
    if ({bus.new_note, bus.note, bus.duration} !== {1'b1, rom_word(7'h20)})
      $display("FAIL pause_resume got=%b/%h exp=1/%h", bus.new_note,
               {bus.note, bus.duration}, rom_word(7'h20));
    else n_pass++;
    tick();
    tick();
    tick();
    n_chk++;
    if (nn_cnt - nn0 !== 1)
      $display("FAIL pause_count got=%0d exp=1", nn_cnt - nn0);
    else n_pass++;
  endtask

  task automatic test_done_with_new_note();
    bit got;
    restart(2'd0);
    tick();
    tick();
    tick();
    n_chk++;
    if (bus.new_note !== 1'b1)
      $display("FAIL early_issue got=%b exp=1", bus.new_note);
    else n_pass++;
    pulse_done();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if ({bus.new_note, bus.note_index} !== 6'd0)
        $display("FAIL early_ignored c=%0d got=%b/%0d exp=0/0", c,
                 bus.new_note, bus.note_index);
      else n_pass++;
    end
    pulse_done();
    n_chk++;
    if (bus.note_index !== 5'd1)
      $display("FAIL early_advance got=%0d exp=1", bus.note_index);
    else n_pass++;
    wait_issue(got);
    n_chk++;
    if (!got || {bus.note, bus.duration} !== rom_word(7'h01))
      $display("FAIL early_next got=%b/%h exp=1/%h", got,
               {bus.note, bus.duration}, rom_word(7'h01));
    else n_pass++;
  endtask

  task automatic test_reset_player_collision();
    bit got;
    int sd0;
    restart(2'd3);
    sd0 = sd_cnt;
    for (int i = 0; i < 7; i++) begin
      wait_issue(got);
      tick();
      pulse_done();
    end
    wait_issue(got);
    n_chk++;
    if (!got || bus.note_index !== 5'd7)
      $display("FAIL rp_reach got=%b/%0d exp=1/7", got, bus.note_index);
    else n_pass++;
    tick();
    bus.reset_player = 1'b1;
    bus.note_done = 1'b1;
    tick();
    bus.reset_player = 1'b0;
    bus.note_done = 1'b0;
    n_chk++;
    if ({bus.new_note, bus.song_done, bus.note_index} !== 7'd0)
      $display("FAIL rp_clear got=%b/%b/%0d exp=0/0/0", bus.new_note,
               bus.song_done, bus.note_index);
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if (bus.new_note !== 1'b0)
      $display("FAIL rp_idle got=%b exp=0", bus.new_note);
    else n_pass++;
    tick();
    n_chk++;
    if ({bus.new_note, bus.note, bus.duration} !== {1'b1, rom_word(7'h60)})
      $display("FAIL rp_restart got=%b/%h exp=1/%h", bus.new_note,
               {bus.note, bus.duration}, rom_word(7'h60));
    else n_pass++;
    n_chk++;
    if (sd_cnt - sd0 !== 0)
      $display("FAIL rp_no_done got=%0d exp=0", sd_cnt - sd0);
    else n_pass++;
  endtask

  task automatic test_end_marker();
    bit got;
    int nn0;
    restart(2'd1);
    for (int i = 0; i < 3; i++) begin
      wait_issue(got);
      n_chk++;
      if (!got || bus.rom_addr !== 7'h20 + 7'(i))
        $display("FAIL marker_pre i=%0d got=%b/%h exp=1/%h", i, got,
                 bus.rom_addr, 7'h20 + 7'(i));
      else n_pass++;
      tick();
      pulse_done();
    end
    nn0 = nn_cnt;
    tick();
    tick();
`ifdef SONG_END_MARKER_EN
    n_chk++;
    if ({bus.new_note, bus.song_done} !== 2'b01)
      $display("FAIL marker_done got=%b exp=01", {bus.new_note, bus.song_done});
    else n_pass++;
    tick();
    bus.play = 1'b0;
    tick();
    n_chk++;
    if (bus.note_index !== 5'd0 || nn_cnt - nn0 !== 0)
      $display("FAIL marker_end got=%0d/%0d exp=0/0", bus.note_index, nn_cnt - nn0);
    else n_pass++;
`else
    n_chk++;
    if ({bus.new_note, bus.note_index, bus.note, bus.duration} !==
        {1'b1, 5'd3, rom_word(7'h23)})
      $display("FAIL marker_plain got=%b/%0d/%h exp=1/3/%h", bus.new_note,
               bus.note_index, {bus.note, bus.duration}, rom_word(7'h23));
    else n_pass++;
    n_chk++;
    if (bus.duration !== 6'd0)
      $display("FAIL marker_dur got=%0d exp=0", bus.duration);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_full_song();
    test_pause_rom_wait();
    test_done_with_new_note();
    test_reset_player_collision();
    test_end_marker();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
